// File: rtl/d5m_pkg.sv
// Shared types and constants for the D5M test-pattern transmitter.
package d5m_pkg;

    // Frame/line sequencing states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FV_LEAD,
        ST_LINE,
        ST_HBLANK,
        ST_FV_TRAIL,
        ST_VBLANK
    } state_e;

    // Pattern codes presented on pattern_sel
    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_SOLID = 2'd3;

    // Bayer site encoding, indexed by {y[0], x[0]}
    localparam logic [1:0] SITE_G0 = 2'b00;
    localparam logic [1:0] SITE_R  = 2'b01;
    localparam logic [1:0] SITE_B  = 2'b10;
    localparam logic [1:0] SITE_G1 = 2'b11;

    // Largest of the timed phase lengths; sizes the shared phase counter
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/d5m_bayer_pixel.sv
// Combinational Bayer test-pattern generator: (x, y, pattern, solid) -> pixel value.
module d5m_bayer_pixel
    import d5m_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int XW        = 10,
    parameter int YW        = 9,
    parameter int BAR_SHIFT = 6
) (
    input  logic [XW-1:0]     x_i,
    input  logic [YW-1:0]     y_i,
    input  logic [1:0]        pat_i,
    input  logic [DATA_W-1:0] solid_i,
    output logic [DATA_W-1:0] pix_o
);

    logic [31:0] xe, ye;
    logic [2:0]  bar;
    logic [1:0]  site;
    logic        chan;

    // Widen coordinates so bit picks (checker uses bit 3) stay legal for narrow counters
    always_comb begin
        xe   = 32'(x_i);
        ye   = 32'(y_i);
        bar  = 3'(xe >> BAR_SHIFT);
        site = {ye[0], xe[0]};
        chan = 1'b0;
        case (site)
            SITE_R:           chan = bar[2];
            SITE_B:           chan = bar[0];
            SITE_G0, SITE_G1: chan = bar[1];
            default:          chan = 1'b0;
        endcase
        pix_o = '0;
        case (pat_i)
            PAT_BARS:  pix_o = chan ? '1 : '0;
            PAT_RAMP:  pix_o = DATA_W'(xe + ye);
            PAT_CHECK: pix_o = (xe[3] ^ ye[3]) ? '1 : '0;
            PAT_SOLID: pix_o = solid_i;
            default:   pix_o = '0;
        endcase
    end

endmodule

// File: rtl/d5m_pattern_tx.sv
// D5M camera-sensor emulator: drives PIXEL_DATA/LINE_VALID/FRAME_VALID with Bayer test patterns.
module d5m_pattern_tx
    import d5m_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int ACTIVE_W  = 640,
    parameter int ACTIVE_H  = 480,
    parameter int H_BLANK   = 16,
    parameter int FV_LEAD   = 4,
    parameter int FV_TRAIL  = 4,
    parameter int V_BLANK   = 32,
    parameter int BAR_SHIFT = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [1:0]        pattern_sel,
    input  logic [DATA_W-1:0] solid_value,
    output logic [DATA_W-1:0] PIXEL_DATA,
    output logic              LINE_VALID,
    output logic              FRAME_VALID,
    output logic [15:0]       frame_count,
    output logic              frame_done
);

    localparam int XW      = (ACTIVE_W > 1) ? $clog2(ACTIVE_W) : 1;
    localparam int YW      = (ACTIVE_H > 1) ? $clog2(ACTIVE_H) : 1;
    localparam int CNT_MAX = max4(FV_LEAD, H_BLANK, FV_TRAIL, V_BLANK);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LEAD_LAST  = CW'(FV_LEAD - 1);
    localparam logic [CW-1:0] HBL_LAST   = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] TRAIL_LAST = CW'(FV_TRAIL - 1);
    localparam logic [CW-1:0] VBL_LAST   = CW'(V_BLANK - 1);
    localparam logic [XW-1:0] X_LAST     = XW'(ACTIVE_W - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(ACTIVE_H - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [1:0]        pat_q;
    logic [DATA_W-1:0] solid_q;
    logic [DATA_W-1:0] pix_q, pix_gen;
    logic              lv_q, fv_q, done_q;
    logic [15:0]       fc_q;
    logic              start_d, done_d;

    // Next-state: phase counter times the blanking phases, x times the active line
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_FV_LEAD;
                    cnt_d   = '0;
                    y_d     = '0;
                    start_d = 1'b1;
                end
            end
            ST_FV_LEAD: begin
                if (cnt_q == LEAD_LAST) begin
                    state_d = ST_LINE;
                    x_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LINE: begin
                if (x_q == X_LAST) begin
                    cnt_d = '0;
                    if (y_q == Y_LAST) begin
                        state_d = ST_FV_TRAIL;
                    end else begin
                        state_d = ST_HBLANK;
                        y_d     = y_q + YW'(1);
                    end
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
            ST_HBLANK: begin
                if (cnt_q == HBL_LAST) begin
                    state_d = ST_LINE;
                    x_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_FV_TRAIL: begin
                if (cnt_q == TRAIL_LAST) begin
                    state_d = ST_VBLANK;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_VBLANK: begin
                if (cnt_q == VBL_LAST) begin
                    cnt_d = '0;
                    if (enable) begin
                        state_d = ST_FV_LEAD;
                        y_d     = '0;
                        start_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pixel for the coordinates the next cycle will present; pattern regs are stable
    // across the frame because LINE is never entered on the latching cycle.
    d5m_bayer_pixel #(
        .DATA_W    (DATA_W),
        .XW        (XW),
        .YW        (YW),
        .BAR_SHIFT (BAR_SHIFT)
    ) u_pix (
        .x_i     (x_d),
        .y_i     (y_d),
        .pat_i   (pat_q),
        .solid_i (solid_q),
        .pix_o   (pix_gen)
    );

    // State, counters, per-frame pattern latch and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pat_q   <= '0;
            solid_q <= '0;
            pix_q   <= '0;
            lv_q    <= 1'b0;
            fv_q    <= 1'b0;
            fc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (start_d) begin
                pat_q   <= pattern_sel;
                solid_q <= solid_value;
                fc_q    <= fc_q + 16'd1;
            end
            fv_q   <= (state_d != ST_IDLE) && (state_d != ST_VBLANK);
            lv_q   <= (state_d == ST_LINE);
            pix_q  <= (state_d == ST_LINE) ? pix_gen : '0;
            done_q <= done_d;
        end
    end

    assign PIXEL_DATA  = pix_q;
    assign LINE_VALID  = lv_q;
    assign FRAME_VALID = fv_q;
    assign frame_count = fc_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_d5m_pattern_tx.sv
// Scoreboard bench for d5m_pattern_tx: driver pushes per-frame expectations, monitor checks the stream.
module tb_d5m_pattern_tx;

    localparam int DATA_W = 12, AW = 8, AH = 4, HB = 2, LEAD = 3, TRAIL = 2, VB = 5, BS = 1;
    localparam int FV_HIGH = LEAD + AW * AH + (AH - 1) * HB + TRAIL;

    logic              clk = 1'b0;
    logic              reset_n, enable;
    logic [1:0]        pattern_sel;
    logic [DATA_W-1:0] solid_value;
    logic [DATA_W-1:0] PIXEL_DATA;
    logic              LINE_VALID, FRAME_VALID, frame_done;
    logic [15:0]       frame_count;

    d5m_pattern_tx #(
        .DATA_W(DATA_W), .ACTIVE_W(AW), .ACTIVE_H(AH), .H_BLANK(HB),
        .FV_LEAD(LEAD), .FV_TRAIL(TRAIL), .V_BLANK(VB), .BAR_SHIFT(BS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
        .solid_value(solid_value), .PIXEL_DATA(PIXEL_DATA), .LINE_VALID(LINE_VALID),
        .FRAME_VALID(FRAME_VALID), .frame_count(frame_count), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct { int cnt; bit b2b; } frm_t;
    frm_t frm_q[$];
    int   pix_q[$];
    int   nvec = 0, nerr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference pixel from the pattern definitions, using plain arithmetic
    function automatic int ref_pix(input int pat, input int solid, input int x, input int y);
        int bar, chan;
        bar = x / (1 << BS);
        case (pat)
            0: begin
                if (y % 2 == 0 && x % 2 == 1)      chan = (bar / 4) % 2;  // red site
                else if (y % 2 == 1 && x % 2 == 0) chan = bar % 2;        // blue site
                else                               chan = (bar / 2) % 2;  // green site
                return chan ? 'hFFF : 0;
            end
            1:       return (x + y) % 4096;
            2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 'hFFF : 0;
            default: return solid % 4096;
        endcase
    endfunction

    task automatic push_frame(input int pat, input int solid, input int cnt, input bit b2b);
        frm_t r;
        for (int y = 0; y < AH; y++)
            for (int x = 0; x < AW; x++)
                pix_q.push_back(ref_pix(pat, solid, x, y));
        r.cnt = cnt;
        r.b2b = b2b;
        frm_q.push_back(r);
    endtask

    // Call from a negedge; returns at the negedge where FRAME_VALID == lvl
    task automatic wait_fv(input logic lvl, input int maxc, input string nm);
        int n = 0;
        while (FRAME_VALID !== lvl && n < maxc) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (n >= maxc) begin
            nerr++;
            $display("FAIL %s: FRAME_VALID=%b, expected %b within %0d cycles", nm, FRAME_VALID, lvl, maxc);
        end
    endtask

    task automatic wait_lv_rises(input int k, input int maxc, input string nm);
        int n = 0, seen = 0;
        logic prev;
        prev = LINE_VALID;
        while (seen < k && n < maxc) begin
            @(negedge clk);
            n++;
            if (LINE_VALID && !prev) seen++;
            prev = LINE_VALID;
        end
        nvec++;
        if (seen < k) begin
            nerr++;
            $display("FAIL %s: saw %0d LINE_VALID rises, expected %0d", nm, seen, k);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_fv"},   FRAME_VALID, 0);
        chk({tag, "_lv"},   LINE_VALID, 0);
        chk({tag, "_pix"},  PIXEL_DATA, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_fc"},   frame_count, 0);
    endtask

    // Monitor: frame/line structure and pixel scoreboard, sampled on the falling edge
    logic prev_fv = 1'b0, prev_lv = 1'b0;
    int   fv_len = 0, lv_len = 0, gap_len = 0, trail_len = 0, vb_len = 0, line_cnt = 0;

    always @(negedge clk) begin
        frm_t rec;
        int   expv;
        if (reset_n !== 1'b1) begin
            prev_fv = 1'b0; prev_lv = 1'b0;
            fv_len = 0; lv_len = 0; gap_len = 0; trail_len = 0; vb_len = 0; line_cnt = 0;
        end else begin
            if (FRAME_VALID && !prev_fv) begin
                if (frm_q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL unexpected_frame: FRAME_VALID rose with no frame scheduled at %0t", $time);
                end else begin
                    rec = frm_q.pop_front();
                    chk("frame_count", frame_count, rec.cnt);
                    if (rec.b2b) chk("vblank_len", vb_len, VB);
                end
                fv_len = 0; line_cnt = 0;
            end
            if (FRAME_VALID) fv_len++;
            if (!FRAME_VALID && prev_fv) begin
                chk("fv_high_len", fv_len, FV_HIGH);
                chk("lines_per_frame", line_cnt, AH);
                chk("fv_trail_len", trail_len, TRAIL);
                chk("frame_done_pulse", frame_done, 1);
                vb_len = 1;
            end else begin
                chk("frame_done_quiet", frame_done, 0);
                if (!FRAME_VALID) vb_len++;
            end
            if (LINE_VALID) begin
                chk("lv_inside_fv", FRAME_VALID, 1);
                if (!prev_lv) begin
                    if (line_cnt == 0) chk("fv_lead_len", fv_len - 1, LEAD);
                    else               chk("hblank_len", gap_len, HB);
                    lv_len = 0;
                end
                lv_len++;
                if (pix_q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL pixel_unexpected: got 0x%0h with no pixel expected", PIXEL_DATA);
                end else begin
                    expv = pix_q.pop_front();
                    chk("pixel", PIXEL_DATA, expv);
                end
            end else begin
                chk("pixel_blank_zero", PIXEL_DATA, 0);
                if (prev_lv) begin
                    chk("lv_len", lv_len, AW);
                    line_cnt++;
                    gap_len = 1;
                    trail_len = 1;
                end else begin
                    gap_len++;
                    if (FRAME_VALID) trail_len++;
                end
            end
            prev_fv = FRAME_VALID;
            prev_lv = LINE_VALID;
        end
    end

    // Driver
    initial begin
        int pat, sol;
        reset_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0; solid_value = '0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");

        // Frame 1: solid 0xABC
        pattern_sel = 2'd3; solid_value = 12'hABC; enable = 1'b1;
        push_frame(3, 'hABC, 1, 1'b0);
        reset_n = 1'b1;
        wait_fv(1'b1, 10, "frame1_start");

        // Frames 2..5, each configured mid-way through the previous frame
        for (int f = 2; f <= 5; f++) begin
            if (f == 2)      begin pat = 1; sol = 0; end
            else if (f == 3) begin pat = 0; sol = 0; end
            else             begin pat = int'($urandom_range(0, 3)); sol = int'($urandom_range(0, 4095)); end
            @(negedge clk);
            pattern_sel = 2'(pat); solid_value = 12'(sol);
            push_frame(pat, sol, f, 1'b1);
            wait_fv(1'b0, 100, "frame_end");
            wait_fv(1'b1, 20, "frame_next_start");
        end

        // Drop enable mid-line 2 of frame 5: frame completes, then no more frames
        wait_lv_rises(3, 60, "frame5_line2");
        repeat (3) @(negedge clk);
        enable = 1'b0;
        pattern_sel = 2'(int'($urandom_range(0, 3)));
        wait_fv(1'b0, 100, "frame5_end");
        repeat (60) @(negedge clk);
        chk("idle_fv", FRAME_VALID, 0);
        chk("idle_frame_count", frame_count, 5);
        chk("idle_pixels_drained", pix_q.size(), 0);

        // Reset mid-frame with a mid-frame pattern switch
        sol = int'($urandom_range(0, 4095));
        pattern_sel = 2'd3; solid_value = 12'(sol); enable = 1'b1;
        push_frame(3, sol, 6, 1'b0);
        wait_fv(1'b1, 10, "frame6_start");
        @(negedge clk);
        pattern_sel = 2'd1;
        wait_lv_rises(2, 60, "frame6_line1");
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        pix_q.delete();
        frm_q.delete();
        @(negedge clk);
        chk_zero_outputs("midreset");
        @(negedge clk);
        push_frame(1, 0, 1, 1'b0);
        reset_n = 1'b1;
        wait_fv(1'b1, 10, "post_reset_start");
        @(negedge clk);
        enable = 1'b0;
        wait_fv(1'b0, 100, "post_reset_end");
        repeat (20) @(negedge clk);
        chk("final_frame_count", frame_count, 1);
        chk("final_pixels_drained", pix_q.size(), 0);
        chk("final_frames_drained", frm_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: run did not complete within 5000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
